// File: rtl/fp_pkg.sv
// Shared constants and state encoding for the FP normalize/pack stage.
// Optional round-to-nearest-even is enabled with the FP_ROUND_EN macro.
package fp_pkg;

    localparam int MANT_WIDTH    = 24;
    localparam int EXP_WIDTH     = 8;
    localparam int EXP_MAX       = 255;
    localparam int EXP_BIAS      = 127;
    localparam int RES_WIDTH     = 1 + EXP_WIDTH + MANT_WIDTH - 1;
    localparam int FRAC_WIDTH    = MANT_WIDTH - 1;
    localparam int EXT_EXP_WIDTH = EXP_WIDTH + 2;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t NORM = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/fp_normalize_pack_if.sv
// Valid/ready bundle between the mantissa ALU, the normalizer and
// the result consumer.
interface fp_normalize_pack_if;
    import fp_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [MANT_WIDTH:0]   mant_in;
    logic [EXP_WIDTH-1:0]  exp_in;
    logic                  sign_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [RES_WIDTH-1:0]  result;
    logic                  overflow;
    logic                  underflow;
    logic                  zero;

    modport master (
        output in_valid,
        output mant_in,
        output exp_in,
        output sign_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  overflow,
        input  underflow,
        input  zero
    );

    modport slave (
        input  in_valid,
        input  mant_in,
        input  exp_in,
        input  sign_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output overflow,
        output underflow,
        output zero
    );

endinterface

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even increment of a normalized fraction; only
// instantiated when FP_ROUND_EN is defined.
module fp_rne_round
    import fp_pkg::*;
(
    input  logic [FRAC_WIDTH-1:0]    i_frac,
    input  logic [EXT_EXP_WIDTH-1:0] i_exp,
    input  logic                     i_guard,
    output logic [FRAC_WIDTH-1:0]    o_frac,
    output logic [EXT_EXP_WIDTH-1:0] o_exp
);

    logic w_inc;
    logic w_carry;

    assign w_inc   = i_guard & i_frac[0];
    // hidden bit is always set, so an all-ones fraction carries out
    assign w_carry = w_inc & (&i_frac);
    assign o_frac  = w_inc ? i_frac + 1'b1 : i_frac;
    assign o_exp   = i_exp
                   + {{(EXT_EXP_WIDTH-1){1'b0}}, w_carry};

endmodule

// File: rtl/fp_normalize_pack.sv
// Iterative one-bit-per-cycle normalizer and IEEE-754 packer.
// Define FP_ROUND_EN to add round-to-nearest-even on the guard bit.
module fp_normalize_pack
    import fp_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    fp_normalize_pack_if.slave bus
);

    localparam logic [EXT_EXP_WIDTH-1:0] EXP_ONE = 1;
    localparam logic [EXT_EXP_WIDTH-1:0] EXP_SAT =
        EXT_EXP_WIDTH'(EXP_MAX);

    state_t                   r_state;
    logic [MANT_WIDTH:0]      r_mant;
    logic [EXT_EXP_WIDTH-1:0] r_exp;
    logic                     r_sign;
    logic [RES_WIDTH-1:0]     r_result;
    logic                     r_ovf;
    logic                     r_unf;
    logic                     r_zero;

    logic                     w_zero_m;
    logic                     w_carry;
    logic                     w_norm;
    logic                     w_low_exp;
    logic [FRAC_WIDTH-1:0]    w_pre_frac;
    logic [EXT_EXP_WIDTH-1:0] w_pre_exp;
    logic [FRAC_WIDTH-1:0]    w_fin_frac;
    logic [EXT_EXP_WIDTH-1:0] w_fin_exp;
    logic                     w_ovf;
    logic [RES_WIDTH-1:0]     w_pack;

    assign w_zero_m  = (r_mant == '0);
    assign w_carry   = r_mant[MANT_WIDTH];
    assign w_norm    = r_mant[MANT_WIDTH-1];
    assign w_low_exp = (r_exp <= EXP_ONE);

    // carry path takes the right-shifted fraction and bumped exponent
    assign w_pre_frac = w_carry ? r_mant[MANT_WIDTH-1:1]
                                : r_mant[MANT_WIDTH-2:0];
    assign w_pre_exp  = w_carry ? r_exp + EXP_ONE : r_exp;

`ifdef FP_ROUND_EN
    logic r_guard;
    logic w_pre_guard;

    assign w_pre_guard = w_carry ? r_mant[0] : r_guard;

    fp_rne_round u_round (
        .i_frac  (w_pre_frac),
        .i_exp   (w_pre_exp),
        .i_guard (w_pre_guard),
        .o_frac  (w_fin_frac),
        .o_exp   (w_fin_exp)
    );
`else
    assign w_fin_frac = w_pre_frac;
    assign w_fin_exp  = w_pre_exp;
`endif

    assign w_ovf  = (w_fin_exp >= EXP_SAT);
    assign w_pack = w_ovf
        ? {r_sign, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}}
        : {r_sign, w_fin_exp[EXP_WIDTH-1:0], w_fin_frac};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mant   <= '0;
            r_exp    <= '0;
            r_sign   <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_zero   <= 1'b0;
`ifdef FP_ROUND_EN
            r_guard  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_mant  <= bus.mant_in;
                        r_exp   <= {{(EXT_EXP_WIDTH-EXP_WIDTH){1'b0}},
                                    bus.exp_in};
                        r_sign  <= bus.sign_in;
                        r_ovf   <= 1'b0;
                        r_unf   <= 1'b0;
                        r_zero  <= 1'b0;
`ifdef FP_ROUND_EN
                        r_guard <= 1'b0;
`endif
                        r_state <= NORM;
                    end
                end
                NORM: begin
                    if (w_zero_m) begin
                        r_result <= '0;
                        r_zero   <= 1'b1;
                        r_state  <= DONE;
                    end else if (w_carry || w_norm) begin
                        r_result <= w_pack;
                        r_ovf    <= w_ovf;
                        r_state  <= DONE;
                    end else if (w_low_exp) begin
                        r_result <= {r_sign, {(RES_WIDTH-1){1'b0}}};
                        r_unf    <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_mant <= {r_mant[MANT_WIDTH-1:0], 1'b0};
                        r_exp  <= r_exp - EXP_ONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.result    = r_result;
    assign bus.overflow  = r_ovf;
    assign bus.underflow = r_unf;
    assign bus.zero      = r_zero;

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Self-checking bench for fp_normalize_pack: directed table, reset
// and backpressure sequences, and randomized beats against a model.
module tb_fp_normalize_pack;

`ifdef FP_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fp_normalize_pack_if bus ();

    fp_normalize_pack dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] g_res;
    logic [2:0]  g_flg;
    int          g_lat;

    typedef struct {
        logic [24:0] m;
        logic [7:0]  e;
        logic        s;
        logic [31:0] r;
        logic [2:0]  f;
        int          lat;
    } vec_t;

    vec_t vt [14];

    function automatic logic [2:0] flags();
        return {bus.overflow, bus.underflow, bus.zero};
    endfunction

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reference: locate the leading one, compute the shift directly.
    function automatic void model(input  logic [24:0] m,
                                  input  logic [7:0]  e8,
                                  input  logic        s,
                                  output logic [31:0] r,
                                  output logic [2:0]  f,
                                  output int          lat);
        int     e;
        int     p;
        int     n;
        longint mm;
        int     ex;
        logic [31:0] exv;
        logic [63:0] mv;
        e = int'(e8);
        if (m == 25'd0) begin
            r = 32'h0; f = 3'b001; lat = 2;
            return;
        end
        p = 24;
        while (!m[p]) p--;
        if (p == 24) begin
            mm = longint'(m) >> 1;
            ex = e + 1;
            lat = 2;
        end else begin
            n = 23 - p;
            if (n > 0 && e <= n) begin
                r = {s, 31'b0}; f = 3'b010;
                lat = 2 + ((e > 1) ? e - 1 : 0);
                return;
            end
            mm = longint'(m) << n;
            ex = e - n;
            lat = 2 + n;
        end
`ifdef FP_ROUND_EN
        if (p == 24 && m[0] && mm[0]) begin
            mm = mm + 1;
            if (mm == (64'd1 << 24)) begin
                mm = 64'd1 << 23;
                ex = ex + 1;
            end
        end
`endif
        exv = ex;
        mv = mm;
        if (ex >= 255) begin
            r = {s, 8'hFF, 23'b0}; f = 3'b100;
        end else begin
            r = {s, exv[7:0], mv[22:0]}; f = 3'b000;
        end
    endfunction

    task automatic run_beat(input logic [24:0] m,
                            input logic [7:0]  e,
                            input logic        s,
                            input int          hold,
                            input logic [31:0] hr,
                            input logic [2:0]  hf);
        int w;
        int lat;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.mant_in  = m;
        bus.exp_in   = e;
        bus.sign_in  = s;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", {31'b0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("out_valid_seen", {31'b0, bus.out_valid}, 32'd1);
        g_res = bus.result;
        g_flg = flags();
        g_lat = lat;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_result", bus.result, hr);
            check("hold_flags", {29'b0, flags()}, {29'b0, hf});
            check("hold_valid", {31'b0, bus.out_valid}, 32'd1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("back_to_idle",
              {30'b0, bus.out_valid, bus.in_ready}, 32'd1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [24:0] rm;
        logic [25:0] mk;
        logic [31:0] rr;
        logic [31:0] rnd;
        logic [7:0]  re;
        logic        rs;
        logic [2:0]  rf;
        int          rl;
        int          seen;

        bus.in_valid  = 1'b0;
        bus.mant_in   = '0;
        bus.exp_in    = '0;
        bus.sign_in   = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_result", bus.result, 32'h0);
        check("rst_flags", {29'b0, flags()}, 32'd0);

        vt[0]  = '{25'h0C00000, 8'h7F, 1'b0, 32'h3FC00000, 3'b000, 2};
        vt[1]  = '{25'h1800000, 8'h7F, 1'b0, 32'h40400000, 3'b000, 2};
        vt[2]  = '{25'h1000003, 8'h7F, 1'b0,
                   RND ? 32'h40000002 : 32'h40000001, 3'b000, 2};
        vt[3]  = '{25'h0000001, 8'h7F, 1'b1, 32'hB4000000, 3'b000, 25};
        vt[4]  = '{25'h0000000, 8'h7F, 1'b1, 32'h00000000, 3'b001, 2};
        vt[5]  = '{25'h1000000, 8'hFE, 1'b0, 32'h7F800000, 3'b100, 2};
        vt[6]  = '{25'h0000100, 8'h03, 1'b0, 32'h00000000, 3'b010, 4};
        vt[7]  = '{25'h0800000, 8'hFF, 1'b1, 32'hFF800000, 3'b100, 2};
        vt[8]  = '{25'h0000001, 8'h01, 1'b1, 32'h80000000, 3'b010, 2};
        vt[9]  = '{25'h1FFFFFF, 8'h7F, 1'b0,
                   RND ? 32'h40800000 : 32'h407FFFFF, 3'b000, 2};
        vt[10] = '{25'h1FFFFFF, 8'hFD, 1'b0,
                   RND ? 32'h7F800000 : 32'h7F7FFFFF,
                   RND ? 3'b100 : 3'b000, 2};
        vt[11] = '{25'h1000001, 8'h7F, 1'b0, 32'h40000000, 3'b000, 2};
        vt[12] = '{25'h0400000, 8'h02, 1'b0, 32'h00800000, 3'b000, 3};
        vt[13] = '{25'h0400000, 8'h01, 1'b0, 32'h00000000, 3'b010, 2};

        for (int i = 0; i < 14; i++) begin
            run_beat(vt[i].m, vt[i].e, vt[i].s,
                     (i == 0) ? 5 : 0, vt[i].r, vt[i].f);
            check($sformatf("vec%0d_result", i), g_res, vt[i].r);
            check($sformatf("vec%0d_flags", i),
                  {29'b0, g_flg}, {29'b0, vt[i].f});
            check($sformatf("vec%0d_latency", i), g_lat, vt[i].lat);
        end

        // abort a long beat with reset while normalizing
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.mant_in  = 25'h0000001;
        bus.exp_in   = 8'h7F;
        bus.sign_in  = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("norm_busy", {31'b0, bus.in_ready}, 32'd0);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", {31'b0, bus.out_valid}, 32'd0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst_mid_result", bus.result, 32'h0);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("rst_no_output", seen, 0);

        run_beat(vt[0].m, vt[0].e, vt[0].s, 0, vt[0].r, vt[0].f);
        check("post_rst_result", g_res, vt[0].r);
        check("post_rst_latency", g_lat, 2);

        for (int i = 0; i < 300; i++) begin
            mk  = (26'd1 << $urandom_range(0, 25)) - 26'd1;
            rnd = $urandom;
            rm  = rnd[24:0] & mk[24:0];
            if ($urandom_range(0, 3) == 0)
                re = 8'($urandom_range(0, 30));
            else
                re = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            model(rm, re, rs, rr, rf, rl);
            run_beat(rm, re, rs, 0, rr, rf);
            check($sformatf("rnd%0d_result m=%h e=%h", i, rm, re),
                  g_res, rr);
            check($sformatf("rnd%0d_flags", i),
                  {29'b0, g_flg}, {29'b0, rf});
            check($sformatf("rnd%0d_latency", i), g_lat, rl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
